pe_comp_sched: RTL and testbench
================================

# pe_comp_sched

Per-PE computation scheduler that drives the memory-address-computation stage of the PE pipeline. For each broadcast input activation accepted from the activation queue, it issues one computation slot per output-activation row held by this PE. Each slot carries the comp_en code, row address, column index, value and layer parameters, and the address stage reads W, U or V SRAM from them. It sits between the PE activation queue and the address-computation stage, and is configured once per layer (or per low-rank phase).

## Interface
- ADDR_W, 12, PE address width: in_act_idx and col_dim.
- ACT_NO_W, 6, output-activation count/address width.
- RANK_W, 5, rank number width.
- DATA_W, 16, activation value width.
- TRUNC_W, 4, truncation amount width.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_valid  in  1  configuration strobe; sampled only in IDLE.
- cfg_mode  in  2  1=W, 2=U, 3=V; 0 is illegal and ignored.
- cfg_row_no  in  ACT_NO_W  output rows owned by this PE.
- cfg_col_dim  in  ADDR_W  W column dimension.
- cfg_rank  in  RANK_W  rank number.
- cfg_in_act_no  in  ACT_NO_W  V column dimension.
- cfg_trunc  in  TRUNC_W  truncation amount.
- act_valid / act_ready  in / out  1  input activation handshake.
- act_idx  in  ADDR_W  input activation index.
- act_value  in  DATA_W  input activation value.
- act_last  in  1  marks the final activation of the layer.
- stall  in  1  downstream back-pressure.
- comp_en  out  2  0=IDLE, 1=W, 2=U, 3=V.
- out_act_addr  out  ACT_NO_W  row address.
- in_act_idx  out  ADDR_W  column index.
- in_act_value  out  DATA_W  activation value.
- col_dim  out  ADDR_W  registered cfg_col_dim.
- rank_no  out  RANK_W  registered cfg_rank.
- in_act_no  out  ACT_NO_W  registered cfg_in_act_no.
- trunc_amount  out  TRUNC_W  registered cfg_trunc.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at layer completion.

## Operation
- **States:** IDLE, WAIT_ACT, ISSUE, DONE.
- **IDLE:**
  - cfg_valid with cfg_mode≠0 latches all cfg_* fields and moves to WAIT_ACT.
  - cfg_valid with cfg_mode=0 is ignored.
  - cfg_valid in any other state is ignored.
- **WAIT_ACT:**
  - act_ready=1.
  - On handshake: latch act_idx, act_value and act_last; clear row counter.
  - Next state: ISSUE if row_no≠0; otherwise DONE if act_last, else stay in WAIT_ACT (the activation is consumed and dropped).
- **ISSUE:**
  - Each non-stalled cycle: comp_en=mode, out_act_addr=row counter, then row counter +1.
  - While stall=1: comp_en=IDLE and the row counter holds, so no SRAM enable is generated.
  - The last row is row counter = row_no−1, not stalled.
  - If latched act_last=1, the next state is DONE.
  - Otherwise act_ready=1 in the last-row cycle (back-to-back). A handshake there reloads the activation and restarts the row counter at 0, staying in ISSUE. No handshake goes to WAIT_ACT.
- **DONE:** done=1 for one cycle, then IDLE. The configuration registers keep their values.
- **Outside ISSUE:** comp_en=IDLE; out_act_addr, in_act_idx and in_act_value are held at their last values.
- **Counter width:** the row counter is ACT_NO_W wide. row_no=2^ACT_NO_W−1 covers addresses 0..2^ACT_NO_W−2, with no wrap.
- **Reset:**
  - State IDLE; all outputs and registers 0; act_ready=0; comp_en=IDLE.
  - Reset mid-ISSUE aborts immediately; no done pulse.

## Timing
- Activation handshake in cycle T gives the first comp_en≠IDLE in T+1.
- Per activation: row_no issue cycles plus stall cycles.
- Steady-state gap between activations is 0 cycles (back-to-back acceptance).
- done asserts in the cycle after the last issue of the act_last activation.
- All outputs are driven from registers or the state decode. The only combinational input-to-output path is stall→comp_en and stall→act_ready.

## Test plan
- **W mode:** cfg row_no=4, col_dim=100. Two activations (idx 5, 9), the second with act_last.
  - comp_en=1 for 8 consecutive cycles.
  - out_act_addr 0,1,2,3,0,1,2,3; in_act_idx 5×4 then 9×4.
  - done one cycle after the 8th issue.
- **Stall:** V mode, row_no=3. Stall high during the 2nd issue cycle for 2 cycles.
  - comp_en shows 3,0,0,3,3; out_act_addr 0,1,1,1,2.
- **Zero rows:** row_no=0, 3 activations, last with act_last.
  - No comp_en≠0 ever; act_ready stays high; done after the 3rd handshake.
- **Config guards:** cfg_valid pulsed during ISSUE and cfg_mode=0 in IDLE.
  - Both ignored: mode, rank_no and busy unchanged.
- **Reset mid-ISSUE:** U mode, row_no=6, assert rst at row 2.
  - Same cycle: comp_en=0, busy=0, all outputs 0, no done pulse.
  - A new cfg after reset behaves normally.
- **Max rows:** row_no=63 (ACT_NO_W=6).
  - out_act_addr runs 0..62 with no wrap, then done.

Source files
------------

// File: rtl/pe_comp_sched.sv
// Per-PE computation scheduler: for each accepted input activation it issues
// one address-stage slot per output row owned by this PE.
module pe_comp_sched #(
    parameter int ADDR_W   = 12,
    parameter int ACT_NO_W = 6,
    parameter int RANK_W   = 5,
    parameter int DATA_W   = 16,
    parameter int TRUNC_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    input  logic [1:0]          cfg_mode,
    input  logic [ACT_NO_W-1:0] cfg_row_no,
    input  logic [ADDR_W-1:0]   cfg_col_dim,
    input  logic [RANK_W-1:0]   cfg_rank,
    input  logic [ACT_NO_W-1:0] cfg_in_act_no,
    input  logic [TRUNC_W-1:0]  cfg_trunc,
    input  logic                act_valid,
    output logic                act_ready,
    input  logic [ADDR_W-1:0]   act_idx,
    input  logic [DATA_W-1:0]   act_value,
    input  logic                act_last,
    input  logic                stall,
    output logic [1:0]          comp_en,
    output logic [ACT_NO_W-1:0] out_act_addr,
    output logic [ADDR_W-1:0]   in_act_idx,
    output logic [DATA_W-1:0]   in_act_value,
    output logic [ADDR_W-1:0]   col_dim,
    output logic [RANK_W-1:0]   rank_no,
    output logic [ACT_NO_W-1:0] in_act_no,
    output logic [TRUNC_W-1:0]  trunc_amount,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [ACT_NO_W-1:0] row_no_q, row_no_d;
    logic [ADDR_W-1:0]   col_dim_q, col_dim_d;
    logic [RANK_W-1:0]   rank_q, rank_d;
    logic [ACT_NO_W-1:0] in_act_no_q, in_act_no_d;
    logic [TRUNC_W-1:0]  trunc_q, trunc_d;
    logic [ACT_NO_W-1:0] row_cnt_q, row_cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   value_q, value_d;
    logic                last_q, last_d;

    logic issue_fire;
    logic last_row;
    logic act_hs;

    assign issue_fire = (state_q == S_ISSUE) && !stall;
    assign last_row   = (row_cnt_q == row_no_q - ACT_NO_W'(1));
    assign act_ready  = (state_q == S_WAIT) || (issue_fire && last_row && !last_q);
    assign act_hs     = act_valid && act_ready;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        row_no_d    = row_no_q;
        col_dim_d   = col_dim_q;
        rank_d      = rank_q;
        in_act_no_d = in_act_no_q;
        trunc_d     = trunc_q;
        row_cnt_d   = row_cnt_q;
        idx_d       = idx_q;
        value_d     = value_q;
        last_d      = last_q;

        if (act_hs) begin
            idx_d   = act_idx;
            value_d = act_value;
            last_d  = act_last;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_valid && (cfg_mode != 2'd0)) begin
                    mode_d      = cfg_mode;
                    row_no_d    = cfg_row_no;
                    col_dim_d   = cfg_col_dim;
                    rank_d      = cfg_rank;
                    in_act_no_d = cfg_in_act_no;
                    trunc_d     = cfg_trunc;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (act_hs) begin
                    if (row_no_q != '0) begin
                        row_cnt_d = '0;
                        state_d   = S_ISSUE;
                    end else if (act_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                // The counter parks on the last row so the address holds after the burst.
                if (issue_fire) begin
                    if (!last_row) begin
                        row_cnt_d = row_cnt_q + ACT_NO_W'(1);
                    end else if (last_q) begin
                        state_d = S_DONE;
                    end else if (act_hs) begin
                        row_cnt_d = '0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            row_no_q    <= '0;
            col_dim_q   <= '0;
            rank_q      <= '0;
            in_act_no_q <= '0;
            trunc_q     <= '0;
            row_cnt_q   <= '0;
            idx_q       <= '0;
            value_q     <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            row_no_q    <= row_no_d;
            col_dim_q   <= col_dim_d;
            rank_q      <= rank_d;
            in_act_no_q <= in_act_no_d;
            trunc_q     <= trunc_d;
            row_cnt_q   <= row_cnt_d;
            idx_q       <= idx_d;
            value_q     <= value_d;
            last_q      <= last_d;
        end
    end

    assign comp_en      = issue_fire ? mode_q : 2'd0;
    assign out_act_addr = row_cnt_q;
    assign in_act_idx   = idx_q;
    assign in_act_value = value_q;
    assign col_dim      = col_dim_q;
    assign rank_no      = rank_q;
    assign in_act_no    = in_act_no_q;
    assign trunc_amount = trunc_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_pe_comp_sched.sv
// Directed bench for pe_comp_sched: each scenario task drives a short layer
// and compares the issued slots against hand-computed sequences.
module tb_pe_comp_sched;

    localparam int ADDR_W   = 12;
    localparam int ACT_NO_W = 6;
    localparam int RANK_W   = 5;
    localparam int DATA_W   = 16;
    localparam int TRUNC_W  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_valid;
    logic [1:0]          cfg_mode;
    logic [ACT_NO_W-1:0] cfg_row_no;
    logic [ADDR_W-1:0]   cfg_col_dim;
    logic [RANK_W-1:0]   cfg_rank;
    logic [ACT_NO_W-1:0] cfg_in_act_no;
    logic [TRUNC_W-1:0]  cfg_trunc;
    logic                act_valid;
    logic                act_ready;
    logic [ADDR_W-1:0]   act_idx;
    logic [DATA_W-1:0]   act_value;
    logic                act_last;
    logic                stall;
    logic [1:0]          comp_en;
    logic [ACT_NO_W-1:0] out_act_addr;
    logic [ADDR_W-1:0]   in_act_idx;
    logic [DATA_W-1:0]   in_act_value;
    logic [ADDR_W-1:0]   col_dim;
    logic [RANK_W-1:0]   rank_no;
    logic [ACT_NO_W-1:0] in_act_no;
    logic [TRUNC_W-1:0]  trunc_amount;
    logic                busy;
    logic                done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_comp_sched #(
        .ADDR_W(ADDR_W), .ACT_NO_W(ACT_NO_W), .RANK_W(RANK_W),
        .DATA_W(DATA_W), .TRUNC_W(TRUNC_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_row_no(cfg_row_no),
        .cfg_col_dim(cfg_col_dim), .cfg_rank(cfg_rank), .cfg_in_act_no(cfg_in_act_no),
        .cfg_trunc(cfg_trunc),
        .act_valid(act_valid), .act_ready(act_ready), .act_idx(act_idx),
        .act_value(act_value), .act_last(act_last), .stall(stall),
        .comp_en(comp_en), .out_act_addr(out_act_addr), .in_act_idx(in_act_idx),
        .in_act_value(in_act_value), .col_dim(col_dim), .rank_no(rank_no),
        .in_act_no(in_act_no), .trunc_amount(trunc_amount), .busy(busy), .done(done)
    );

    task automatic drive_cfg(input logic [1:0] mode, input int rows, input int cdim, input int rank);
        cfg_valid     = 1'b1;
        cfg_mode      = mode;
        cfg_row_no    = ACT_NO_W'(rows);
        cfg_col_dim   = ADDR_W'(cdim);
        cfg_rank      = RANK_W'(rank);
        cfg_in_act_no = 6'd7;
        cfg_trunc     = 4'd3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (comp_en !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || act_ready !== 1'b0 ||
            out_act_addr !== '0 || in_act_idx !== '0 || col_dim !== '0 || rank_no !== '0) begin
            errors++;
            $display("FAIL reset_state: comp_en=%0d busy=%0d done=%0d ready=%0d addr=%0d idx=%0d, required all 0",
                     comp_en, busy, done, act_ready, out_act_addr, in_act_idx);
        end
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_w_mode();
        drive_cfg(2'd1, 4, 100, 2);
        @(negedge clk);
        cfg_valid = 1'b0; act_valid = 1'b1; act_idx = 12'd5; act_value = 16'h1111; act_last = 1'b0;
        #1;
        checks++;
        if (act_ready !== 1'b1 || busy !== 1'b1 || col_dim !== 12'd100 || trunc_amount !== 4'd3 || in_act_no !== 6'd7) begin
            errors++;
            $display("FAIL w_wait: ready=%0d busy=%0d col_dim=%0d trunc=%0d in_act_no=%0d, required 1 1 100 3 7",
                     act_ready, busy, col_dim, trunc_amount, in_act_no);
        end
        @(negedge clk);
        act_idx = 12'd9; act_value = 16'h2222; act_last = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (comp_en !== 2'd1 || out_act_addr !== ACT_NO_W'(k % 4) ||
                in_act_idx !== ((k < 4) ? 12'd5 : 12'd9) || act_ready !== (k == 3)) begin
                errors++;
                $display("FAIL w_issue%0d: comp_en=%0d addr=%0d idx=%0d ready=%0d, required 1 %0d %0d %0d",
                         k, comp_en, out_act_addr, in_act_idx, act_ready, k % 4, (k < 4) ? 5 : 9, k == 3);
            end
            @(negedge clk);
            if (k == 3) act_valid = 1'b0;
        end
        #1;
        checks++;
        if (done !== 1'b1 || comp_en !== 2'd0 || out_act_addr !== 6'd3 || in_act_value !== 16'h2222) begin
            errors++;
            $display("FAIL w_done: done=%0d comp_en=%0d addr=%0d value=%h, required 1 0 3 2222",
                     done, comp_en, out_act_addr, in_act_value);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL w_idle: done=%0d busy=%0d, required 0 0", done, busy);
        end
        $display("txn w_mode two activations complete");
    endtask

    int stall_v[5] = '{0, 1, 1, 0, 0};
    int exp_ce[5]  = '{3, 0, 0, 3, 3};
    int exp_ad[5]  = '{0, 1, 1, 1, 2};

    task automatic test_stall();
        drive_cfg(2'd3, 3, 40, 1);
        @(negedge clk);
        cfg_valid = 1'b0; act_valid = 1'b1; act_idx = 12'd4; act_last = 1'b1;
        @(negedge clk);
        act_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            stall = stall_v[k][0];
            #1;
            checks++;
            if (comp_en !== 2'(exp_ce[k]) || out_act_addr !== ACT_NO_W'(exp_ad[k])) begin
                errors++;
                $display("FAIL stall_cyc%0d: comp_en=%0d addr=%0d, required %0d %0d",
                         k, comp_en, out_act_addr, exp_ce[k], exp_ad[k]);
            end
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: done=%0d, required 1", done);
        end
        @(negedge clk);
        $display("txn stall V-mode activation complete");
    endtask

    task automatic test_zero_rows();
        drive_cfg(2'd1, 0, 10, 1);
        @(negedge clk);
        cfg_valid = 1'b0; act_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            act_idx = ADDR_W'(j + 1); act_last = (j == 2);
            #1;
            checks++;
            if (act_ready !== 1'b1 || comp_en !== 2'd0 || done !== 1'b0) begin
                errors++;
                $display("FAIL zero_rows_hs%0d: ready=%0d comp_en=%0d done=%0d, required 1 0 0",
                         j, act_ready, comp_en, done);
            end
            @(negedge clk);
        end
        act_valid = 1'b0; act_last = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || comp_en !== 2'd0) begin
            errors++;
            $display("FAIL zero_rows_done: done=%0d comp_en=%0d, required 1 0", done, comp_en);
        end
        @(negedge clk);
        $display("txn zero_rows three activations dropped");
    endtask

    task automatic test_cfg_guards();
        drive_cfg(2'd1, 2, 55, 5);
        @(negedge clk);
        cfg_valid = 1'b0; act_valid = 1'b1; act_idx = 12'd8; act_last = 1'b1;
        @(negedge clk);
        act_valid = 1'b0;
        drive_cfg(2'd2, 9, 77, 9);
        #1;
        checks++;
        if (comp_en !== 2'd1 || rank_no !== 5'd5) begin
            errors++;
            $display("FAIL guard_issue0: comp_en=%0d rank=%0d, required 1 5", comp_en, rank_no);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (comp_en !== 2'd1 || out_act_addr !== 6'd1 || rank_no !== 5'd5 || col_dim !== 12'd55 || busy !== 1'b1) begin
            errors++;
            $display("FAIL guard_issue1: comp_en=%0d addr=%0d rank=%0d col=%0d busy=%0d, required 1 1 5 55 1",
                     comp_en, out_act_addr, rank_no, col_dim, busy);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL guard_done: done=%0d, required 1", done);
        end
        @(negedge clk);
        drive_cfg(2'd0, 9, 77, 9);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rank_no !== 5'd5 || col_dim !== 12'd55) begin
            errors++;
            $display("FAIL guard_mode0: busy=%0d rank=%0d col=%0d, required 0 5 55", busy, rank_no, col_dim);
        end
        $display("txn cfg_guards complete");
    endtask

    task automatic test_reset_mid_issue();
        drive_cfg(2'd2, 6, 300, 3);
        @(negedge clk);
        cfg_valid = 1'b0; act_valid = 1'b1; act_idx = 12'd11; act_value = 16'h3333; act_last = 1'b0;
        @(negedge clk);
        act_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (comp_en !== 2'd2 || out_act_addr !== ACT_NO_W'(k)) begin
                errors++;
                $display("FAIL rst_pre%0d: comp_en=%0d addr=%0d, required 2 %0d", k, comp_en, out_act_addr, k);
            end
            if (k < 2) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (comp_en !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || act_ready !== 1'b0 ||
            out_act_addr !== '0 || in_act_idx !== '0 || in_act_value !== '0 ||
            col_dim !== '0 || rank_no !== '0 || trunc_amount !== '0) begin
            errors++;
            $display("FAIL rst_abort: comp_en=%0d busy=%0d done=%0d addr=%0d idx=%0d col=%0d rank=%0d, required all 0",
                     comp_en, busy, done, out_act_addr, in_act_idx, col_dim, rank_no);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done: done=%0d busy=%0d, required 0 0", done, busy);
        end
        rst = 1'b0;
        drive_cfg(2'd1, 2, 20, 4);
        @(negedge clk);
        cfg_valid = 1'b0; act_valid = 1'b1; act_idx = 12'd6; act_last = 1'b1;
        @(negedge clk);
        act_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (comp_en !== 2'd1 || out_act_addr !== ACT_NO_W'(k) || in_act_idx !== 12'd6) begin
                errors++;
                $display("FAIL rst_after%0d: comp_en=%0d addr=%0d idx=%0d, required 1 %0d 6",
                         k, comp_en, out_act_addr, in_act_idx, k);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (done !== 1'b1 || rank_no !== 5'd4) begin
            errors++;
            $display("FAIL rst_after_done: done=%0d rank=%0d, required 1 4", done, rank_no);
        end
        @(negedge clk);
        $display("txn reset_mid_issue and recovery complete");
    endtask

    task automatic test_max_rows();
        drive_cfg(2'd1, 63, 1, 1);
        @(negedge clk);
        cfg_valid = 1'b0; act_valid = 1'b1; act_idx = 12'd20; act_last = 1'b1;
        @(negedge clk);
        act_valid = 1'b0;
        for (int k = 0; k < 63; k++) begin
            #1;
            checks++;
            if (comp_en !== 2'd1 || out_act_addr !== ACT_NO_W'(k) || done !== 1'b0) begin
                errors++;
                $display("FAIL max_row%0d: comp_en=%0d addr=%0d done=%0d, required 1 %0d 0",
                         k, comp_en, out_act_addr, done, k);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (done !== 1'b1 || comp_en !== 2'd0 || out_act_addr !== 6'd62) begin
            errors++;
            $display("FAIL max_done: done=%0d comp_en=%0d addr=%0d, required 1 0 62", done, comp_en, out_act_addr);
        end
        @(negedge clk);
        $display("txn max_rows 63-row activation complete");
    endtask

    initial begin
        cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_row_no = '0; cfg_col_dim = '0;
        cfg_rank = '0; cfg_in_act_no = '0; cfg_trunc = '0;
        act_valid = 1'b0; act_idx = '0; act_value = '0; act_last = 1'b0; stall = 1'b0;
        test_reset();
        test_w_mode();
        test_stall();
        test_zero_rows();
        test_cfg_guards();
        test_reset_mid_issue();
        test_max_rows();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
